// File: rtl/trng_ro_sampler.sv
// trng_ro_sampler: turns an asynchronous ring-oscillator signal into packed,
// bias-corrected random words. The path is a two-flop synchroniser, a
// programmable sample divider, a repetition-count health test, a von Neumann
// corrector, a shift-register packer and a one-word holding register.
//
// Handshake: RND_VALID=1 means RND_DATA holds a word nobody has taken yet.
// The word is consumed on any rising CLK edge where RND_VALID and RND_READY
// are both 1. RND_DATA does not change while RND_VALID=1 and RND_READY=0.
// A new word may be loaded in the same cycle the previous one is consumed,
// so RND_VALID can stay high across back-to-back words.
module trng_ro_sampler #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned REP_LIMIT = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             EN,
    input  logic             RO_IN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             RND_READY,
    output logic [WIDTH-1:0] RND_DATA,
    output logic             RND_VALID,
    output logic             OVERRUN,
    output logic             ALARM
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

    // synchroniser
    logic sync1;
    logic sync2;

    // divider
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    // health test
    logic          prev_raw;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_next;

    // von Neumann corrector
    logic phase;
    logic first_bit;
    logic take;
    logic vn_valid;
    logic vn_bit;

    // packer and transfer
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    pcount;
    logic             full;
    logic             hold_free;
    logic             xfer;
    logic             drop;

    // Two-flop synchroniser; runs regardless of EN so it is settled when
    // sampling starts.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= RO_IN;
            sync2 <= sync1;
        end
    end

    // A tick fires when the counter meets DIV. A counter already beyond a
    // newly lowered DIV simply wraps through the maximum count.
    assign tick = EN && (div_cnt == DIV);

    // Sample divider counter: cleared while disabled, reloads 0 on a tick.
    always_ff @(posedge CLK) begin
        if (!RESETn || !EN) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Next run length: a zero count marks the first sample after enable.
    always_comb begin
        run_next = run_cnt;
        if (tick) begin
            if ((run_cnt == '0) || (sync2 != prev_raw)) begin
                run_next = RW'(1);
            end else if (run_cnt != REP_MAX) begin
                run_next = run_cnt + 1'b1;
            end
        end
    end

    // Repetition-count state: previous raw bit and saturating run length.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            prev_raw <= 1'b0;
            run_cnt  <= '0;
        end else if (!EN) begin
            run_cnt  <= '0;
        end else begin
            run_cnt <= run_next;
            if (tick) begin
                prev_raw <= sync2;
            end
        end
    end

    // Sticky health alarm, cleared only by reset or by dropping EN.
    always_ff @(posedge CLK) begin
        if (!RESETn || !EN) begin
            ALARM <= 1'b0;
        end else if (tick && (run_next == REP_MAX)) begin
            ALARM <= 1'b1;
        end
    end

    // The corrector freezes while the alarm is up, so no bits leave it.
    assign take = tick && !ALARM;

    // Second bit of a pair: emit the first bit when the two differ.
    always_comb begin
        vn_valid = take && phase && (first_bit != sync2);
        vn_bit   = first_bit;
    end

    // Pair phase and stored first bit; pairs never overlap.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            phase     <= 1'b0;
            first_bit <= 1'b0;
        end else if (!EN) begin
            phase     <= 1'b0;
        end else if (take) begin
            if (!phase) begin
                first_bit <= sync2;
            end
            phase <= ~phase;
        end
    end

    // Transfer needs a full packer and a free holding register; a bit that
    // meets a full, blocked packer is lost.
    always_comb begin
        full      = (pcount == FULL_CNT);
        hold_free = !RND_VALID || RND_READY;
        xfer      = EN && !ALARM && full && hold_free;
        drop      = vn_valid && full && !xfer;
    end

    // Packer: new bits enter at bit 0; a bit arriving with a transfer starts
    // the next word.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            shreg  <= '0;
            pcount <= '0;
        end else if (!EN) begin
            pcount <= '0;
        end else begin
            if (xfer) begin
                pcount <= vn_valid ? CW'(1) : '0;
            end else if (vn_valid && !full) begin
                pcount <= pcount + CW'(1);
            end
            if (vn_valid && (!full || xfer)) begin
                shreg <= {shreg[WIDTH-2:0], vn_bit};
            end
        end
    end

    // Holding register: kept across EN=0 until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            RND_DATA  <= '0;
            RND_VALID <= 1'b0;
        end else if (xfer) begin
            RND_DATA  <= shreg;
            RND_VALID <= 1'b1;
        end else if (RND_READY) begin
            RND_VALID <= 1'b0;
        end
    end

    // Sticky overrun flag, cleared by reset or by dropping EN.
    always_ff @(posedge CLK) begin
        if (!RESETn || !EN) begin
            OVERRUN <= 1'b0;
        end else if (drop) begin
            OVERRUN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trng_ro_sampler.sv
// tb_trng_ro_sampler: directed scenarios followed by randomized segments,
// with every output compared each cycle against a behavioural model.
module tb_trng_ro_sampler;

    localparam int W = 8;

    // clock / reset and DUT signals
    logic         clk;
    logic         resetn;
    logic         en;
    logic         ro_in;
    logic [7:0]   div;
    logic         rnd_ready;
    logic [W-1:0] rnd_data;
    logic         rnd_valid;
    logic         overrun;
    logic         alarm;

    int vectors;
    int miscompares;
    int valid_seen;

    // reference model state
    bit           ro_q[$];
    int           m_k;
    int           m_run;
    bit           m_prev;
    bit           m_pair[$];
    bit           m_bits[$];
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_overrun;
    bit           m_alarm;

    trng_ro_sampler #(.WIDTH(W), .DIV_W(8), .REP_LIMIT(32)) dut (
        .CLK       (clk),
        .RESETn    (resetn),
        .EN        (en),
        .RO_IN     (ro_in),
        .DIV       (div),
        .RND_READY (rnd_ready),
        .RND_DATA  (rnd_data),
        .RND_VALID (rnd_valid),
        .OVERRUN   (overrun),
        .ALARM     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        ro_q.delete();
        ro_q.push_back(1'b0);
        ro_q.push_back(1'b0);
        m_k = 0;
        m_run = 0;
        m_prev = 1'b0;
        m_pair.delete();
        m_bits.delete();
        m_data = '0;
        m_valid = 1'b0;
        m_overrun = 1'b0;
        m_alarm = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        bit raw;
        bit tick;
        bit alarm_old;
        bit have_bit;
        bit cbit;
        bit is_full;
        bit do_xfer;
        logic [W-1:0] word;
        if (!resetn) begin
            model_reset();
            return;
        end
        raw = ro_q.pop_front();
        ro_q.push_back(ro_in);
        if (!en) begin
            m_k = 0;
            m_run = 0;
            m_pair.delete();
            m_bits.delete();
            m_overrun = 1'b0;
            m_alarm = 1'b0;
            if (m_valid && rnd_ready) m_valid = 1'b0;
            return;
        end
        tick = ((m_k % (int'(div) + 1)) == int'(div));
        m_k++;
        alarm_old = m_alarm;
        have_bit = 1'b0;
        cbit = 1'b0;
        if (tick) begin
            if (m_run == 0 || raw != m_prev) m_run = 1;
            else m_run++;
            m_prev = raw;
            if (m_run >= 32) m_alarm = 1'b1;
            if (!alarm_old) begin
                m_pair.push_back(raw);
                if (m_pair.size() == 2) begin
                    if (m_pair[0] != m_pair[1]) begin
                        have_bit = 1'b1;
                        cbit = m_pair[0];
                    end
                    m_pair.delete();
                end
            end
        end
        is_full = (m_bits.size() == W);
        do_xfer = is_full && (!m_valid || rnd_ready) && !alarm_old;
        if (do_xfer) begin
            word = '0;
            for (int i = 0; i < W; i++) word[W-1-i] = m_bits[i];
            m_data = word;
            m_valid = 1'b1;
            m_bits.delete();
        end else if (m_valid && rnd_ready) begin
            m_valid = 1'b0;
        end
        if (have_bit) begin
            if (m_bits.size() < W) m_bits.push_back(cbit);
            else m_overrun = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: model step, edge, then sample outputs at the falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("valid", {7'b0, rnd_valid}, {7'b0, m_valid});
        chk("data", rnd_data, m_data);
        chk("overrun", {7'b0, overrun}, {7'b0, m_overrun});
        chk("alarm", {7'b0, alarm}, {7'b0, m_alarm});
        if (rnd_valid) valid_seen++;
    endtask

    // Two enable-low cycles to align the raw stream, then n_en enabled cycles.
    task automatic run_pattern(input bit [3:0] pat, input int n_en, input bit ready);
        for (int i = 0; i < n_en + 2; i++) begin
            en = (i >= 2);
            ro_in = pat[i % 4];
            rnd_ready = ready;
            cycle();
        end
    endtask

    initial begin
        int n;
        int len;
        int bias;
        int rdy_pct;
        vectors = 0;
        miscompares = 0;
        valid_seen = 0;
        resetn = 1'b0;
        en = 1'b1;
        ro_in = 1'b0;
        div = 8'd0;
        rnd_ready = 1'b0;
        model_reset();

        // reset with EN high and RO_IN toggling
        for (int i = 0; i < 3; i++) begin
            ro_in = i[0];
            cycle();
        end
        chk("reset_valid", {7'b0, rnd_valid}, 8'd0);
        chk("reset_data", rnd_data, 8'd0);
        chk("reset_overrun", {7'b0, overrun}, 8'd0);
        chk("reset_alarm", {7'b0, alarm}, 8'd0);
        resetn = 1'b1;

        // corrector and packing: raw 0,1,1,0 -> 0x55, one pulse
        div = 8'd0;
        valid_seen = 0;
        run_pattern(4'b0110, 17, 1'b1);
        chk("word_55", rnd_data, 8'h55);
        chk("word_55_pulses", 8'(valid_seen), 8'd1);
        en = 1'b0;
        cycle();
        chk("word_55_consumed", {7'b0, rnd_valid}, 8'd0);

        // discard: raw 1,1,0,0 -> nothing
        valid_seen = 0;
        run_pattern(4'b0011, 40, 1'b1);
        chk("discard_words", 8'(valid_seen), 8'd0);
        chk("discard_alarm", {7'b0, alarm}, 8'd0);

        // health test: constant 1, DIV=3
        en = 1'b0;
        div = 8'd3;
        ro_in = 1'b1;
        rnd_ready = 1'b1;
        cycle();
        cycle();
        en = 1'b1;
        valid_seen = 0;
        n = 0;
        while (n < 200 && !alarm) begin
            cycle();
            n++;
        end
        chk("alarm_set", {7'b0, alarm}, 8'd1);
        chk("alarm_latency", 8'(n), 8'd128);
        for (int i = 0; i < 20; i++) cycle();
        chk("alarm_sticky", {7'b0, alarm}, 8'd1);
        chk("alarm_no_words", 8'(valid_seen), 8'd0);
        en = 1'b0;
        cycle();
        chk("alarm_cleared", {7'b0, alarm}, 8'd0);

        // backpressure: 24 corrected bits with READY low
        div = 8'd0;
        run_pattern(4'b0110, 48, 1'b0);
        chk("bp_valid", {7'b0, rnd_valid}, 8'd1);
        chk("bp_data", rnd_data, 8'h55);
        chk("bp_overrun", {7'b0, overrun}, 8'd1);
        rnd_ready = 1'b1;
        cycle();
        chk("bp_b2b_valid", {7'b0, rnd_valid}, 8'd1);
        rnd_ready = 1'b0;

        // EN drop mid-word with a word pending
        run_pattern(4'b0110, 10, 1'b0);
        chk("mid_pending", {7'b0, rnd_valid}, 8'd1);
        en = 1'b0;
        rnd_ready = 1'b1;
        cycle();
        chk("mid_delivered", {7'b0, rnd_valid}, 8'd0);
        valid_seen = 0;
        run_pattern(4'b1001, 17, 1'b1);
        chk("mid_new_word", rnd_data, 8'hAA);
        chk("mid_new_pulses", 8'(valid_seen), 8'd1);

        // randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            en = 1'b0;
            div = 8'($urandom_range(0, 3));
            bias = ($urandom_range(0, 4) == 0) ? 97 : 50;
            rdy_pct = ($urandom_range(0, 3) == 0) ? 10 : 75;
            if ($urandom_range(0, 9) == 0) resetn = 1'b0;
            cycle();
            resetn = 1'b1;
            len = $urandom_range(20, 300);
            for (int j = 0; j < len; j++) begin
                en = 1'b1;
                ro_in = ($urandom_range(0, 99) < bias);
                rnd_ready = ($urandom_range(0, 99) < rdy_pct);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
